reg_file_4: RTL and testbench
=============================

# reg_file_4

Small register file that stores the 4-bit values the processor datapath produces and returns them on two independently addressed read ports. It complements the single 4-bit capture register: that register takes one value in, and this block serves stored values back out to the operand-fetch stage. It has one write port and two read ports. Reads are registered and flagged with a one-cycle valid strobe, and a read of the entry being written in the same cycle returns the new data.

## Interface
- WIDTH, 4, data width of each entry in bits
- DEPTH, 4, number of entries; must be a power of two
- ADDR_W, 2, address width; must equal log2(DEPTH)

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; asynchronous, active-low (rst=0 resets)
- we  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  WIDTH  write data
- re_a  input  1  read request, port A
- raddr_a  input  ADDR_W  read address, port A
- rdata_a  output  WIDTH  registered read data, port A
- rvalid_a  output  1  high for one cycle when rdata_a carries a new result
- re_b  input  1  read request, port B
- raddr_b  input  ADDR_W  read address, port B
- rdata_b  output  WIDTH  registered read data, port B
- rvalid_b  output  1  high for one cycle when rdata_b carries a new result

## Operation
- Storage: DEPTH x WIDTH flops, mem[0..DEPTH-1].
- Write: on a rising edge with we=1, mem[waddr] <= wdata. With we=0, storage holds.
- Read, per port X in {A, B}, on a rising edge:
  - re_X=1: rdata_X <= mem[raddr_X] and rvalid_X <= 1.
  - re_X=0: rdata_X holds its previous value and rvalid_X <= 0.
- Write-through bypass: if we=1, re_X=1 and raddr_X==waddr on the same edge, then rdata_X <= wdata, not the old contents.
- The two ports are fully independent. Both may read the same address on the same edge, and each returns the identical value.
- Address range is always exactly 0..DEPTH-1 because DEPTH is a power of two, so there is no out-of-range case.
- Reset (rst=0), asynchronous:
  - every mem entry becomes 0
  - rdata_a and rdata_b become 0
  - rvalid_a and rvalid_b become 0
  - all of the above take effect immediately, independent of clk
- While rst=0, we, re_a and re_b are ignored. An in-flight read is discarded: its rvalid never asserts.
- The first edge with rst=1 operates normally. Release of rst is assumed synchronous to clk; reset-release synchronization is upstream.

## Timing
- Write latency: data is stored at the edge that samples we=1. A read requested on any later edge returns the new value; a read on the same edge returns it through the bypass.
- Read latency: 1 cycle. A request sampled at edge N gives rdata_X/rvalid_X valid from just after edge N, until edge N+1.
- Back-to-back reads are allowed every cycle. rvalid_X stays high continuously while re_X is held high.
- No backpressure: the consumer must capture rdata_X in the cycle rvalid_X is high. rdata_X is still held afterwards for convenience.
- No combinational path from any input to any output.
- Reset values: rdata_a=0, rdata_b=0, rvalid_a=0, rvalid_b=0, mem[*]=0.

## Test plan
- Reset: drive rst=0 for 2 cycles, then release. Read addresses 0..3 on both ports -> each rdata=4'b0000 with rvalid=1 one cycle after each request.
- Write then read: write 4'b1111 to addr 1, then next cycle re_a=1 with raddr_a=1 -> rdata_a=4'b1111 and rvalid_a=1 one cycle later. Then write 4'b0000 to addr 1 and read again -> rdata_a=4'b0000.
- Bypass: we=1, waddr=2, wdata=4'b1010 on the same edge as re_b=1, raddr_b=2 -> next cycle rdata_b=4'b1010. On that same edge port A reads addr 3 (holding 4'b0101) -> rdata_a=4'b0101.
- Dual read, idle hold: fill addrs 0..3 with 4'h3, 4'h6, 4'h9, 4'hC; read A=0 and B=3 together -> 4'h3 and 4'hC. Then drop re -> rvalid_a=rvalid_b=0 while the rdata values hold.
- Reset mid-operation: after filling memory, assert rst=0 between clock edges while re_a=1 is pending -> all outputs go 0 immediately and no rvalid pulse follows. After release, reading addr 2 returns 4'b0000.
- Streaming: hold re_a=1 and sweep raddr_a 0,1,2,3 on consecutive cycles -> rvalid_a stays high for 4 cycles, with rdata_a equal to the stored values in order.

Source files
------------

// File: rtl/reg_file_4.sv
// reg_file_4: 4x4 register file, one write port, two registered read ports with valid strobes.
// Same-edge read of the entry being written returns the new data.
module reg_file_4 #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    output logic              rvalid_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              rvalid_b
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata_a, r_rdata_b;
    logic             r_rvalid_a, r_rvalid_b;
    logic             w_byp_a, w_byp_b;

    assign w_byp_a = we && (raddr_a == waddr);
    assign w_byp_b = we && (raddr_b == waddr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rdata_a  <= '0;
            r_rdata_b  <= '0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
        end else begin
            if (we) r_mem[waddr] <= wdata;
            if (re_a) r_rdata_a <= w_byp_a ? wdata : r_mem[raddr_a];
            if (re_b) r_rdata_b <= w_byp_b ? wdata : r_mem[raddr_b];
            r_rvalid_a <= re_a;
            r_rvalid_b <= re_b;
        end
    end

    assign rdata_a  = r_rdata_a;
    assign rdata_b  = r_rdata_b;
    assign rvalid_a = r_rvalid_a;
    assign rvalid_b = r_rvalid_b;
endmodule

// File: tb/tb_reg_file_4.sv
// tb_reg_file_4: directed plus randomized checks of reg_file_4 against a write-then-read array model.
module tb_reg_file_4;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       we = 1'b0, re_a = 1'b0, re_b = 1'b0;
    logic [1:0] waddr = '0, raddr_a = '0, raddr_b = '0;
    logic [3:0] wdata = '0;
    logic [3:0] rdata_a, rdata_b;
    logic       rvalid_a, rvalid_b;

    int         n_checks = 0, n_errors = 0;
    logic [3:0] m_mem [4];
    logic [3:0] m_rd_a = '0, m_rd_b = '0;
    logic       m_rv_a = 1'b0, m_rv_b = 1'b0;

    reg_file_4 dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " rdata_a"}, rdata_a, m_rd_a);
        check({tag, " rvalid_a"}, {3'b0, rvalid_a}, {3'b0, m_rv_a});
        check({tag, " rdata_b"}, rdata_b, m_rd_b);
        check({tag, " rvalid_b"}, {3'b0, rvalid_b}, {3'b0, m_rv_b});
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_mem[i] = '0;
        m_rd_a = '0;
        m_rd_b = '0;
        m_rv_a = 1'b0;
        m_rv_b = 1'b0;
    endtask

    task automatic drv(input logic w, input logic [1:0] wa, input logic [3:0] wd,
                       input logic ea, input logic [1:0] aa, input logic eb, input logic [1:0] ab);
        we = w; waddr = wa; wdata = wd;
        re_a = ea; raddr_a = aa; re_b = eb; raddr_b = ab;
    endtask

    // A same-edge write is visible to the read, so apply the write before reading the array.
    task automatic step(input string tag);
        @(posedge clk);
        if (!rst) model_clear();
        else begin
            if (we) m_mem[waddr] = wdata;
            if (re_a) m_rd_a = m_mem[raddr_a];
            if (re_b) m_rd_b = m_mem[raddr_b];
            m_rv_a = re_a;
            m_rv_b = re_b;
        end
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1 model_clear();
        check_all({tag, " async"});
        step({tag, " in_reset"});
        @(negedge clk) rst = 1'b1;
    endtask

    initial begin
        model_clear();
        #1 check_all("reset_state");
        repeat (2) step("reset_hold");
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 0, 1, 2'(i), 1, 2'(i));
            step("reset_read");
        end
        drv(1, 1, 4'hF, 0, 0, 0, 0); step("wr1");
        drv(0, 0, 0, 1, 1, 0, 0);    step("rd1_f");
        drv(1, 1, 4'h0, 0, 0, 0, 0); step("wr1_0");
        drv(0, 0, 0, 1, 1, 0, 0);    step("rd1_0");
        drv(1, 3, 4'h5, 0, 0, 0, 0); step("wr3");
        drv(1, 2, 4'hA, 1, 3, 1, 2); step("bypass");
        drv(1, 0, 4'h3, 0, 0, 0, 0); step("fill0");
        drv(1, 1, 4'h6, 0, 0, 0, 0); step("fill1");
        drv(1, 2, 4'h9, 0, 0, 0, 0); step("fill2");
        drv(1, 3, 4'hC, 0, 0, 0, 0); step("fill3");
        drv(0, 0, 0, 1, 0, 1, 3);    step("dual");
        drv(0, 0, 0, 0, 0, 0, 0);    step("idle_hold");
        drv(0, 0, 0, 1, 2, 0, 0);
        async_reset("mid_reset");
        drv(0, 0, 0, 1, 2, 0, 0);    step("post_reset_rd2");
        for (int i = 0; i < 4; i++) begin
            drv(1, 2'(i), 4'(i * 5 + 1), 0, 0, 0, 0);
            step("stream_fill");
        end
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 0, 1, 2'(i), 0, 0);
            step("stream");
        end
        for (int n = 0; n < 400; n++) begin
            drv(1'($urandom), 2'($urandom), 4'($urandom), 1'($urandom),
                2'($urandom), 1'($urandom), 2'($urandom));
            if ($urandom_range(0, 49) == 0) async_reset("rand_reset");
            else step("rand");
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
